// File: rtl/mips_mc_control_pkg.sv
// rtl/mips_mc_control_pkg.sv - shared state codes and helpers for the MIPS multi-cycle sequencer
package mips_mc_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } mc_state_e;

  // Any instruction that touches the data side of the shared memory port.
  function automatic logic needs_mem(input logic rd, input logic ww, input logic wb,
                                     input logic addm);
    return rd | ww | wb | addm;
  endfunction

endpackage

// File: rtl/mips_mc_control_mem_wait_timer.sv
// rtl/mips_mc_control_mem_wait_timer.sv - stall counter that flags a memory request as timed out
module mips_mc_control_mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (stall) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the stall cycles already spent, so this cycle is the WAIT_LIMIT-th one.
  assign expired = (WAIT_LIMIT != 0) && stall && (cnt_q == LAST);

endmodule

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the shared memory port
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_writeenable,
  input  logic             dec_mem_read,
  input  logic             dec_word_we,
  input  logic             dec_byte_we,
  input  logic             dec_addm,
  input  logic             dec_except,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic             mem_wr_word,
  output logic             mem_wr_byte,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] retired_count
);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  logic req_c, sel_c, wr_word_c, wr_byte_c, ir_we_c, rf_we_c, pc_we_c, halted_c;
  logic expired, timer_clear, stall;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    req_c     = 1'b0;
    sel_c     = 1'b0;
    wr_word_c = 1'b0;
    wr_byte_c = 1'b0;
    ir_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    halted_c  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: state_d = dec_except ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (needs_mem(dec_mem_read, dec_word_we, dec_byte_we, dec_addm)) begin
          state_d = ST_MEM;
        end else if (dec_writeenable) begin
          state_d = ST_WB;
        end else begin
          pc_we_c = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        req_c     = 1'b1;
        sel_c     = 1'b1;
        wr_word_c = dec_word_we;
        wr_byte_c = dec_byte_we;
        if (mem_ready) begin
          if (dec_word_we || dec_byte_we) begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted_c = 1'b1;
      default: state_d = ST_HALT;
    endcase
    if (pc_we_c) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall       = req_c & ~mem_ready;
  assign timer_clear = mem_ready | (state_d != state_q);

  mips_mc_control_mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .WAIT_W    (WAIT_W)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .stall  (stall),
    .expired(expired)
  );

  // Strobes are forced low during reset so an in-flight request is dropped at once.
  assign mem_req       = req_c & ~reset;
  assign mem_addr_sel  = sel_c;
  assign mem_wr_word   = wr_word_c & ~reset;
  assign mem_wr_byte   = wr_byte_c & ~reset;
  assign ir_we         = ir_we_c & ~reset;
  assign rf_we         = rf_we_c & ~reset;
  assign pc_we         = pc_we_c & ~reset;
  assign halted        = halted_c;
  assign state         = state_q;
  assign timeout       = timeout_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - trace-model and table-driven bench for mips_mc_control
module tb_mips_mc_control;

  localparam int CNT_W = 4;
  localparam int WL    = 15;
  localparam int MOD   = 1 << CNT_W;
  localparam int C_ALU = 0, C_BR = 1, C_LW = 2, C_ADDM = 3, C_SW = 4, C_SB = 5, C_EXC = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dec_writeenable = 1'b0, dec_mem_read = 1'b0, dec_word_we = 1'b0;
  logic dec_byte_we = 1'b0, dec_addm = 1'b0, dec_except = 1'b0, mem_ready = 1'b0;
  logic [2:0] state;
  logic mem_req, mem_addr_sel, mem_wr_word, mem_wr_byte, ir_we, rf_we, pc_we, halted, timeout;
  logic [CNT_W-1:0] retired_count;

  always #5 clock = ~clock;

  mips_mc_control #(.CNT_W(CNT_W), .WAIT_LIMIT(WL), .WAIT_W(4)) dut (
    .clock(clock), .reset(reset),
    .dec_writeenable(dec_writeenable), .dec_mem_read(dec_mem_read),
    .dec_word_we(dec_word_we), .dec_byte_we(dec_byte_we),
    .dec_addm(dec_addm), .dec_except(dec_except), .mem_ready(mem_ready),
    .state(state), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel),
    .mem_wr_word(mem_wr_word), .mem_wr_byte(mem_wr_byte), .ir_we(ir_we),
    .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .timeout(timeout),
    .retired_count(retired_count)
  );

  // One expected bus cycle; strb = {req, sel, wr_word, wr_byte, ir_we, rf_we, pc_we}.
  typedef struct {
    bit       rst;
    bit       rdy;
    bit [5:0] dec;
    bit       chk_st;
    bit [2:0] st;
    bit [6:0] strb;
    bit       hlt;
    bit       to;
    int       cnt;
  } cyc_t;

  typedef struct {
    int c, fw, mw, cyc, pc, rf;
    bit h, t;
  } dir_t;

  cyc_t q[$];
  dir_t tbl[11];
  int   m_cnt = 0;
  bit   m_to = 1'b0;
  int   checks = 0, failures = 0;
  int   obs_cyc, obs_pc, obs_rf;
  bit   obs_h, obs_t;

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Decoder outputs {writeenable, mem_read, word_we, byte_we, addm, except} per class.
  function automatic bit [5:0] dec_of(input int c);
    case (c)
      C_ALU:   return 6'b100000;
      C_LW:    return 6'b110000;
      C_ADDM:  return 6'b100010;
      C_SW:    return 6'b001000;
      C_SB:    return 6'b000100;
      C_EXC:   return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
    end
  endtask

  task automatic add(input bit rst, input bit rdy, input bit [5:0] dec, input bit [2:0] st,
                     input bit [6:0] strb);
    cyc_t r;
    r.rst = rst; r.rdy = rdy; r.dec = dec; r.chk_st = !rst; r.st = st;
    r.strb = rst ? 7'b0 : strb; r.hlt = (st == 3'd5); r.to = m_to; r.cnt = m_cnt;
    q.push_back(r);
    if (!rst && strb[0]) m_cnt = (m_cnt + 1) % MOD;
    if (rst) begin
      m_cnt = 0;
      m_to  = 1'b0;
    end
  endtask

  task automatic halt_and_reset(input bit to);
    if (to) m_to = 1'b1;
    add(1'b0, rb(), 6'($urandom), 3'd5, 7'b0);
    add(1'b0, rb(), 6'($urandom), 3'd5, 7'b0);
    add(1'b1, rb(), 6'($urandom), 3'd0, 7'b0);
  endtask

  // Expected trace of one instruction: fw/mw are not-ready cycles before ready in FETCH/MEM.
  task automatic plan(input int c, input int fw, input int mw);
    bit [5:0] d = dec_of(c);
    bit       store = (c == C_SW) || (c == C_SB);
    bit [6:0] ms = {2'b11, d[3], d[2], 3'b000};
    for (int i = 0; i < fw && i < WL; i++) add(1'b0, 1'b0, 6'($urandom), 3'd0, 7'b1000000);
    if (fw >= WL) begin halt_and_reset(1'b1); return; end
    add(1'b0, 1'b1, 6'($urandom), 3'd0, 7'b1000100);
    add(1'b0, rb(), d, 3'd1, 7'b0);
    if (c == C_EXC) begin halt_and_reset(1'b0); return; end
    if (c == C_BR) begin add(1'b0, rb(), d, 3'd2, 7'b0000001); return; end
    add(1'b0, rb(), d, 3'd2, 7'b0);
    if (c == C_ALU) begin add(1'b0, rb(), d, 3'd4, 7'b0000011); return; end
    for (int i = 0; i < mw && i < WL; i++) add(1'b0, 1'b0, d, 3'd3, ms);
    if (mw >= WL) begin halt_and_reset(1'b1); return; end
    add(1'b0, 1'b1, d, 3'd3, ms | {6'b0, store});
    if (!store) add(1'b0, rb(), d, 3'd4, 7'b0000011);
  endtask

  task automatic run_q();
    cyc_t     r;
    bit [6:0] mask;
    while (q.size() > 0) begin
      r = q.pop_front();
      reset = r.rst;
      mem_ready = r.rdy;
      {dec_writeenable, dec_mem_read, dec_word_we, dec_byte_we, dec_addm, dec_except} = r.dec;
      #3;
      mask = r.strb[6] ? 7'h7f : 7'b1011111;
      chk("strobes", 32'({mem_req, mem_addr_sel, mem_wr_word, mem_wr_byte, ir_we, rf_we, pc_we} & mask),
          32'(r.strb & mask));
      if (r.chk_st) begin
        chk("state", 32'(state), 32'(r.st));
        chk("halted", 32'(halted), 32'(r.hlt));
      end
      chk("timeout", 32'(timeout), 32'(r.to));
      chk("count", 32'(retired_count), 32'(r.cnt));
      if (!r.rst && halted !== 1'b1) obs_cyc++;
      if (pc_we === 1'b1) obs_pc++;
      if (rf_we === 1'b1) obs_rf++;
      if (halted === 1'b1) obs_h = 1'b1;
      if (timeout === 1'b1) obs_t = 1'b1;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic reset_dut();
    add(1'b1, rb(), 6'($urandom), 3'd0, 7'b0);
    run_q();
  endtask

  initial begin
    // class, fetch waits, mem waits, active cycles, pc pulses, rf pulses, halted, timeout
    tbl[0]  = '{C_ALU,  0,  0,  4, 1, 1, 1'b0, 1'b0};
    tbl[1]  = '{C_BR,   0,  0,  3, 1, 0, 1'b0, 1'b0};
    tbl[2]  = '{C_SW,   0,  0,  4, 1, 0, 1'b0, 1'b0};
    tbl[3]  = '{C_SB,   0,  2,  6, 1, 0, 1'b0, 1'b0};
    tbl[4]  = '{C_LW,   0,  3,  8, 1, 1, 1'b0, 1'b0};
    tbl[5]  = '{C_ADDM, 0,  0,  5, 1, 1, 1'b0, 1'b0};
    tbl[6]  = '{C_EXC,  0,  0,  2, 0, 0, 1'b1, 1'b0};
    tbl[7]  = '{C_ALU,  15, 0, 15, 0, 0, 1'b1, 1'b1};
    tbl[8]  = '{C_BR,   14, 0, 17, 1, 0, 1'b0, 1'b0};
    tbl[9]  = '{C_SW,   0, 15, 18, 0, 0, 1'b1, 1'b1};
    tbl[10] = '{C_LW,   0, 14, 19, 1, 1, 1'b0, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    chk("reset_strobes", 32'({mem_req, mem_wr_word, mem_wr_byte, ir_we, rf_we, pc_we}), 32'd0);

    foreach (tbl[i]) begin
      reset_dut();
      obs_cyc = 0; obs_pc = 0; obs_rf = 0; obs_h = 1'b0; obs_t = 1'b0;
      plan(tbl[i].c, tbl[i].fw, tbl[i].mw);
      run_q();
      chk($sformatf("tbl%0d_cycles", i), 32'(obs_cyc), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_pc_we", i), 32'(obs_pc), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_rf_we", i), 32'(obs_rf), 32'(tbl[i].rf));
      chk($sformatf("tbl%0d_halted", i), 32'(obs_h), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_timeout", i), 32'(obs_t), 32'(tbl[i].t));
    end

    // Reset while a load is stalled in MEM.
    reset_dut();
    add(1'b0, 1'b1, 6'($urandom), 3'd0, 7'b1000100);
    add(1'b0, 1'b0, dec_of(C_LW), 3'd1, 7'b0);
    add(1'b0, 1'b0, dec_of(C_LW), 3'd2, 7'b0);
    add(1'b0, 1'b0, dec_of(C_LW), 3'd3, 7'b1100000);
    add(1'b0, 1'b0, dec_of(C_LW), 3'd3, 7'b1100000);
    add(1'b1, 1'b0, dec_of(C_LW), 3'd0, 7'b0);
    add(1'b0, 1'b0, 6'($urandom), 3'd0, 7'b1000000);
    run_q();

    // Retired count wraps from MOD-1 to 0.
    reset_dut();
    for (int i = 0; i < MOD + 1; i++) plan(C_BR, 0, 0);
    run_q();
    chk("wrap_count", 32'(retired_count), 32'd1);

    // Random instruction mix against the trace model.
    reset_dut();
    for (int n = 0; n < 200; n++) begin
      int c, fw, mw;
      c  = ($urandom_range(0, 29) == 0) ? C_EXC : int'($urandom_range(0, 5));
      fw = ($urandom_range(0, 39) == 0) ? int'($urandom_range(14, 15)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 39) == 0) ? int'($urandom_range(14, 15)) : int'($urandom_range(0, 3));
      plan(c, fw, mw);
      run_q();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
